// File: rtl/cache_line_refill_fsm.sv
// Line-refill controller: streams one cache line of word reads from pipelined memory into the data array.
// Optional macro CRITICAL_WORD_FIRST_EN starts the fill at the missing word instead of word 0.
module cache_line_refill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_LINE  = 8,
    parameter int BYTE_OFF        = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_tag_array,
    output logic              fsm_busy,
    output logic              fill_done
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = ADDR_W - OFF_W - BYTE_OFF;
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   base_q, base_d;
    logic [OFF_W-1:0]   start_q, start_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;

    logic [CNT_W-1:0]   outstanding;
    logic [OFF_W-1:0]   issue_idx, ret_idx;
    logic               ret_fire, issue_fire, last_ret;

    logic unused_low_bits;
    assign unused_low_bits = ^miss_address[OFF_W+BYTE_OFF-1:0];

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] b,
                                                     input logic [OFF_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_W-1:BYTE_OFF] = {b, idx};
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            start_q     <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            start_q     <= start_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign outstanding = issue_cnt_q - ret_cnt_q;
    assign issue_idx   = start_q + issue_cnt_q[OFF_W-1:0];
    assign ret_idx     = start_q + ret_cnt_q[OFF_W-1:0];
    // A return arriving this cycle frees its slot immediately so latency == MAX_OUTSTANDING still streams.
    assign ret_fire    = (state_q == FILL) && mem_data_valid && (ret_cnt_q != issue_cnt_q);
    assign issue_fire  = (state_q == FILL) && (issue_cnt_q < CNT_W'(WORDS_PER_LINE))
                         && ((outstanding - CNT_W'(ret_fire)) < CNT_W'(MAX_OUTSTANDING));
    assign last_ret    = ret_fire && (ret_cnt_q == CNT_W'(WORDS_PER_LINE - 1));

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        start_d          = start_q;
        issue_cnt_d      = issue_cnt_q;
        ret_cnt_d        = ret_cnt_q;
        mem_enable       = 1'b0;
        mem_address      = '0;
        write_data_array = 1'b0;
        write_address    = '0;
        write_data       = '0;
        write_tag_array  = 1'b0;
        fsm_busy         = 1'b0;
        fill_done        = 1'b0;

        case (state_q)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_d     = FILL;
                    base_d      = miss_address[ADDR_W-1:OFF_W+BYTE_OFF];
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d     = miss_address[OFF_W+BYTE_OFF-1:BYTE_OFF];
`else
                    start_d     = '0;
`endif
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_fire) begin
                    mem_enable  = 1'b1;
                    mem_address = line_addr(base_q, issue_idx);
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (ret_fire) begin
                    write_data_array = 1'b1;
                    write_address    = line_addr(base_q, ret_idx);
                    write_data       = mem_data;
                    ret_cnt_d        = ret_cnt_q + CNT_W'(1);
                end
                if (last_ret) begin
                    write_tag_array = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: begin
                fsm_busy  = 1'b1;
                fill_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset takes effect on the outputs in the same cycle so an aborted fill writes nothing more.
        if (rst) begin
            mem_enable       = 1'b0;
            mem_address      = '0;
            write_data_array = 1'b0;
            write_address    = '0;
            write_data       = '0;
            write_tag_array  = 1'b0;
            fsm_busy         = 1'b0;
            fill_done        = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_line_refill_fsm.sv
// Bench for cache_line_refill_fsm: latency-programmable memory model plus scoreboard of expected reads/writes.
module tb_cache_line_refill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic        mem_enable;
    logic [15:0] mem_address;
    logic        write_data_array;
    logic [15:0] write_address;
    logic [15:0] write_data;
    logic        write_tag_array;
    logic        fsm_busy;
    logic        fill_done;

    logic        mdl_vld, stray_vld;
    logic [15:0] mdl_dat, stray_dat;

    assign mem_data_valid = mdl_vld | stray_vld;
    assign mem_data       = stray_vld ? stray_dat : mdl_dat;

    always #5 clk = ~clk;

    cache_line_refill_fsm dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid), .mem_enable(mem_enable),
        .mem_address(mem_address), .write_data_array(write_data_array),
        .write_address(write_address), .write_data(write_data),
        .write_tag_array(write_tag_array), .fsm_busy(fsm_busy), .fill_done(fill_done)
    );

    typedef logic [15:0] seq_t [8];
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] pend_addr[$];
    int          pend_due[$];

    int cyc = 0;
    int lat = 4;
    int n_checks = 0;
    int n_fail = 0;
    int issued = 0, returned = 0, wr_seen = 0, done_cnt = 0;
    int tag_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected none (cycle %0d)", name, act, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: data for a read issued in cycle c appears in cycle c+lat.
    initial begin
        mdl_vld = 1'b0;
        mdl_dat = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                mdl_vld = 1'b1;
                mdl_dat = pend_addr[0] ^ 16'h5A5A;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mdl_vld = 1'b0;
                mdl_dat = '0;
            end
        end
    end

    // Monitor: compares every read and array write against the scoreboard.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (mem_enable) begin
            issued++;
            pend_addr.push_back(mem_address);
            pend_due.push_back(cyc + lat);
            if (exp_rd.size() == 0) flag("unexpected_read", mem_address);
            else chk("read_addr", mem_address, exp_rd.pop_front());
        end else begin
            chk("read_addr_zero_when_idle", mem_address, 0);
        end
        if (mdl_vld) returned++;
        chk("outstanding_le_max", ((issued - returned) <= 4), 1);
        if (write_data_array) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                flag("unexpected_write", write_address);
            end else begin
                e = exp_wr.pop_front();
                chk("write_addr", write_address, e.addr);
                chk("write_data", write_data, e.data);
                chk("write_tag", write_tag_array, e.tag);
            end
            if (write_tag_array) tag_cyc = cyc;
        end else begin
            chk("write_addr_zero_when_idle", write_address, 0);
            chk("tag_without_write", write_tag_array, 0);
        end
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic push_fill(input seq_t seq);
        for (int i = 0; i < 8; i++) begin
            exp_rd.push_back(seq[i]);
            exp_wr.push_back('{addr: seq[i], data: seq[i] ^ 16'h5A5A, tag: (i == 7)});
        end
    endtask

    task automatic run_fill(input logic [15:0] miss, input seq_t seq, input int l, input int done_off);
        int acc, d0, n, busy_bad;
        bit seen;
        lat = l;
        push_fill(seq);
        @(posedge clk);
        #1;
        miss_detected = 1'b1;
        miss_address  = miss;
        acc = cyc;
        d0  = done_cnt;
        #1;
        chk("busy_in_miss_cycle", fsm_busy, 1);
        busy_bad = 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 3) miss_detected = 1'b0;
            #1;
            if (!fsm_busy) busy_bad++;
            if (fill_done) seen = 1'b1;
        end
        chk("fill_done_seen", seen, 1);
        chk("busy_through_fill", busy_bad, 0);
        @(negedge clk);
        chk("tag_write_cycle", tag_cyc - acc, done_off - 1);
        chk("fill_done_cycle", done_cyc - acc, done_off);
        repeat (2) @(posedge clk);
        #1;
        chk("fill_done_single_pulse", done_cnt - d0, 1);
        chk("idle_not_busy", fsm_busy, 0);
        chk("all_reads_issued", exp_rd.size(), 0);
        chk("all_writes_seen", exp_wr.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        seq_t s1, s2, s3, s4;
        int w0, d0, n;
`ifdef CRITICAL_WORD_FIRST_EN
        s1 = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
        s3 = '{16'h0F0E, 16'h0F00, 16'h0F02, 16'h0F04, 16'h0F06, 16'h0F08, 16'h0F0A, 16'h0F0C};
`else
        s1 = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
        s3 = '{16'h0F00, 16'h0F02, 16'h0F04, 16'h0F06, 16'h0F08, 16'h0F0A, 16'h0F0C, 16'h0F0E};
`endif
        s2 = '{16'hABC0, 16'hABC2, 16'hABC4, 16'hABC6, 16'hABC8, 16'hABCA, 16'hABCC, 16'hABCE};
        s4 = '{16'h2200, 16'h2202, 16'h2204, 16'h2206, 16'h2208, 16'h220A, 16'h220C, 16'h220E};

        rst = 1'b1;
        miss_detected = 1'b1;
        miss_address = 16'h1236;
        stray_vld = 1'b0;
        stray_dat = '0;
        @(posedge clk);
        #1;
        chk("reset_busy_low_with_miss", fsm_busy, 0);
        chk("reset_mem_enable", mem_enable, 0);
        chk("reset_write_enable", write_data_array, 0);
        chk("reset_fill_done", fill_done, 0);
        repeat (2) @(posedge clk);
        #1;
        miss_detected = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_busy", fsm_busy, 0);
        chk("post_reset_mem_enable", mem_enable, 0);

        run_fill(16'h1236, s1, 4, 13);

        // Stray return data while idle must not reach the array.
        @(posedge clk);
        #1;
        w0 = wr_seen;
        d0 = done_cnt;
        stray_vld = 1'b1;
        stray_dat = 16'hBEEF;
        repeat (2) @(posedge clk);
        #1;
        stray_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("stray_valid_no_write", wr_seen - w0, 0);
        chk("stray_valid_not_busy", fsm_busy, 0);
        chk("stray_valid_no_done", done_cnt - d0, 0);

        run_fill(16'hABC0, s2, 2, 11);
        run_fill(16'h0F0E, s3, 6, 17);

        // Abort a fill with reset after the third return.
        lat = 4;
        push_fill(s4);
        @(posedge clk);
        #1;
        miss_detected = 1'b1;
        miss_address = 16'h2200;
        w0 = wr_seen;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        n = 0;
        while (wr_seen < w0 + 3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("three_returns_before_reset", wr_seen - w0, 3);
        rst = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        #1;
        chk("abort_mem_enable", mem_enable, 0);
        chk("abort_write_enable", write_data_array, 0);
        chk("abort_tag", write_tag_array, 0);
        chk("abort_busy", fsm_busy, 0);
        chk("abort_addr", mem_address, 0);
        w0 = wr_seen;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("late_valids_no_write", wr_seen - w0, 0);
        chk("abort_idle", fsm_busy, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("inflight_drained", issued - returned, 0);

        run_fill(16'h1236, s1, 4, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
